// File: rtl/addsub_bcd_serial_if.sv
// Handshake and data bundle for the digit-serial BCD/binary adder-subtractor.
// The master drives the operation; the slave reports status and results.
interface addsub_bcd_serial_if #(
  parameter int DIGITS = 4,
  parameter int NW     = $clog2(DIGITS + 1)
);
  localparam int W = 4 * DIGITS;

  logic          ce;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ci;
  logic          add;
  logic          bcd;
  logic [NW-1:0] ndig;
  logic          busy;
  logic          done;
  logic [W-1:0]  s;
  logic          co;
  logic          vo;
  logic          zo;
  logic          no;

  modport master (
    output ce, start, a, b, ci, add, bcd, ndig,
    input  busy, done, s, co, vo, zo, no
  );

  modport slave (
    input  ce, start, a, b, ci, add, bcd, ndig,
    output busy, done, s, co, vo, zo, no
  );
endinterface

// File: rtl/addsub_bcd_serial.sv
// Digit-serial add/subtract, one 4-bit digit per enabled clock,
// with optional decimal correction and flags from the top active digit.
module addsub_bcd_serial #(
  parameter int DIGITS = 4,
  parameter int NW     = $clog2(DIGITS + 1)
) (
  input logic clk,
  input logic rst_n,
  addsub_bcd_serial_if.slave io
);
  localparam int W = 4 * DIGITS;
  localparam logic [NW-1:0] DMAX = NW'(DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } st_t;

  st_t           st;
  logic [NW-1:0] k;
  logic [NW-1:0] n;
  logic [NW-1:0] neff;
  logic [W-1:0]  ra;
  logic [W-1:0]  rb;
  logic [W-1:0]  s;
  logic          cy;
  logic          radd;
  logic          rbcd;
  logic          zacc;
  logic          busy;
  logic          done;
  logic          co;
  logic          vo;
  logic          zo;
  logic          no;
  logic [3:0]    da;
  logic [3:0]    db;
  logic [3:0]    dig;
  logic [4:0]    t;
  logic [3:0]    lo;
  logic          cyn;
  logic          vn;

  always_comb begin
    neff = io.ndig;
    if (io.ndig == '0 || io.ndig > DMAX)
      neff = DMAX;
  end

  // lo recovers the carry into bit 3 for the overflow flag
  always_comb begin
    da  = ra[3:0];
    db  = radd ? rb[3:0] : ~rb[3:0];
    t   = {1'b0, da} + {1'b0, db} + {4'd0, cy};
    lo  = {1'b0, da[2:0]} + {1'b0, db[2:0]} + {3'd0, cy};
    vn  = lo[3] ^ t[4];
    dig = t[3:0];
    cyn = t[4];
    if (radd) begin
      if (rbcd && t > 5'd9) begin
        dig = t[3:0] + 4'd6;
        cyn = 1'b1;
      end
    end else if (rbcd && !t[4]) begin
      dig = t[3:0] - 4'd6;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      k    <= '0;
      n    <= '0;
      ra   <= '0;
      rb   <= '0;
      s    <= '0;
      cy   <= 1'b0;
      radd <= 1'b0;
      rbcd <= 1'b0;
      zacc <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      co   <= 1'b0;
      vo   <= 1'b0;
      zo   <= 1'b0;
      no   <= 1'b0;
    end else if (io.ce) begin
      unique case (st)
        IDLE, FIN: begin
          done <= 1'b0;
          if (io.start) begin
            ra   <= io.a;
            rb   <= io.b;
            cy   <= io.ci;
            radd <= io.add;
            rbcd <= io.bcd;
            n    <= neff;
            s    <= '0;
            k    <= '0;
            zacc <= 1'b1;
            co   <= 1'b0;
            vo   <= 1'b0;
            zo   <= 1'b0;
            no   <= 1'b0;
            busy <= 1'b1;
            st   <= RUN;
          end else begin
            st <= IDLE;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++)
            if (k == NW'(i))
              s[4*i +: 4] <= dig;
          ra   <= ra >> 4;
          rb   <= rb >> 4;
          cy   <= cyn;
          zacc <= zacc && (dig == 4'd0);
          k    <= k + 1'b1;
          if (k == n - 1'b1) begin
            co   <= cyn;
            vo   <= vn;
            no   <= dig[3];
            zo   <= zacc && (dig == 4'd0);
            busy <= 1'b0;
            done <= 1'b1;
            st   <= FIN;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign io.busy = busy;
  assign io.done = done;
  assign io.s    = s;
  assign io.co   = co;
  assign io.vo   = vo;
  assign io.zo   = zo;
  assign io.no   = no;

endmodule

// File: tb/tb_addsub_bcd_serial.sv
// Scoreboard bench for addsub_bcd_serial: directed operands with
// hand-computed results, latency, stall, reset and back-to-back cases.
module tb_addsub_bcd_serial;
  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        vo;
    logic        zo;
    logic        no;
    int          lat;
    int          t0;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   nchk;
  int   nerr;
  exp_t sb[$];

  addsub_bcd_serial_if #(.DIGITS(4)) io ();

  addsub_bcd_serial #(.DIGITS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // pops on the last enabled DONE cycle, so a stalled FIN is seen once
  always @(negedge clk) begin
    if (rst_n && io.done && io.ce) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("s", {16'd0, io.s}, {16'd0, e.s});
        check("co", {31'd0, io.co}, {31'd0, e.co});
        check("vo", {31'd0, io.vo}, {31'd0, e.vo});
        check("zo", {31'd0, io.zo}, {31'd0, e.zo});
        check("no", {31'd0, io.no}, {31'd0, e.no});
        check("busy_in_fin", {31'd0, io.busy}, 32'd0);
        check("latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic setop(input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic add,
                       input logic bcd, input logic [2:0] nd);
    io.a    = a;
    io.b    = b;
    io.ci   = ci;
    io.add  = add;
    io.bcd  = bcd;
    io.ndig = nd;
  endtask

  task automatic push(input logic [15:0] s, input logic co,
                      input logic vo, input logic zo,
                      input logic no, input int lat);
    exp_t e;
    e.s   = s;
    e.co  = co;
    e.vo  = vo;
    e.zo  = zo;
    e.no  = no;
    e.lat = lat;
    e.t0  = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((io.busy || io.done) && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (i >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  // issue one op; expected latency in edges after the accepting edge
  task automatic go(input logic [15:0] a, input logic [15:0] b,
                    input logic ci, input logic add,
                    input logic bcd, input logic [2:0] nd,
                    input logic [15:0] s, input logic co,
                    input logic vo, input logic zo,
                    input logic no, input int lat);
    wait_idle();
    setop(a, b, ci, add, bcd, nd);
    io.start = 1'b1;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    push(s, co, vo, zo, no, lat);
  endtask

  initial begin
    cyc      = 0;
    nchk     = 0;
    nerr     = 0;
    rst_n    = 1'b0;
    io.ce    = 1'b1;
    io.start = 1'b0;
    setop(16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, io.busy}, 32'd0);
    check("rst_done", {31'd0, io.done}, 32'd0);
    check("rst_s", {16'd0, io.s}, 32'd0);
    check("rst_flags", {28'd0, io.co, io.vo, io.zo, io.no}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    go(16'h0099, 16'h0001, 0, 1, 1, 3'd2, 16'h0000, 1, 0, 1, 0, 2);
    drain();
    go(16'h1000, 16'h0001, 1, 0, 1, 3'd4, 16'h0999, 1, 0, 0, 0, 4);
    drain();
    go(16'h7FFF, 16'h0001, 0, 1, 0, 3'd4, 16'h8000, 0, 1, 0, 1, 4);
    drain();
    go(16'h0000, 16'h0001, 1, 0, 1, 3'd2, 16'h0099, 0, 0, 0, 1, 2);
    drain();
    go(16'h0000, 16'h0001, 1, 0, 1, 3'd0, 16'h9999, 0, 0, 0, 1, 4);
    drain();
    go(16'h0000, 16'h0001, 1, 0, 1, 3'd7, 16'h9999, 0, 0, 0, 1, 4);
    drain();
    go(16'h1234, 16'h1234, 1, 0, 0, 3'd4, 16'h0000, 1, 0, 1, 0, 4);
    drain();
    go(16'h1234, 16'h5678, 0, 1, 1, 3'd4, 16'h6912, 0, 0, 0, 0, 4);
    drain();
    go(16'h5559, 16'h7778, 1, 1, 0, 3'd1, 16'h0002, 1, 1, 0, 0, 1);
    drain();
    go(16'h000F, 16'h000F, 0, 1, 1, 3'd1, 16'h0004, 1, 0, 0, 0, 1);
    drain();

    // stall three enabled edges mid-run
    go(16'h1234, 16'h5678, 0, 1, 1, 3'd4, 16'h6912, 0, 0, 0, 0, 7);
    @(posedge clk);
    #1;
    io.ce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    io.ce = 1'b1;
    drain();

    // start with other operands while running
    go(16'h7FFF, 16'h0001, 0, 1, 0, 3'd4, 16'h8000, 0, 1, 0, 1, 4);
    setop(16'h1111, 16'h2222, 1, 0, 1, 3'd1);
    io.start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    io.start = 1'b0;
    drain();

    // reset mid-run: abandon, nothing expected
    wait_idle();
    setop(16'h1234, 16'h5678, 0, 1, 1, 3'd4);
    io.start = 1'b1;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, io.busy}, 32'd0);
    check("midrst_done", {31'd0, io.done}, 32'd0);
    check("midrst_s", {16'd0, io.s}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    go(16'h0099, 16'h0001, 0, 1, 1, 3'd2, 16'h0000, 1, 0, 1, 0, 2);
    drain();

    // back-to-back: start held through FIN
    go(16'h0099, 16'h0001, 0, 1, 1, 3'd2, 16'h0000, 1, 0, 1, 0, 2);
    setop(16'h1000, 16'h0001, 1, 0, 1, 3'd4);
    io.start = 1'b1;
    begin
      int i;
      i = 0;
      while (!io.done && i < 50) begin
        @(posedge clk);
        #1;
        i++;
      end
      if (i >= 50) check("b2b_timeout", 32'd1, 32'd0);
    end
    @(posedge clk);
    #1;
    io.start = 1'b0;
    push(16'h0999, 1, 0, 0, 0, 4);
    check("b2b_busy", {31'd0, io.busy}, 32'd1);
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
